vga_timing_gen: RTL

- Generates the raster scan that palettized sprite/background renderers consume: DrawX/DrawY pixel coordinates, the active-video `blank` flag, and the hs/vs sync pulses.
- Sits between the pixel clock source and every `*_example` renderer.
- Sync and blank outputs have a programmable delay so they line up with the renderers' registered colour output (ROM read on negedge, colour latched on posedge).

---
 rtl/vga_pkg.sv | 24 ++
 rtl/vga_if.sv | 21 ++
 rtl/vga_delay_line.sv | 37 +++
 rtl/vga_param_chk.sv | 20 ++
 rtl/vga_timing_gen.sv | 98 +++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Default 640x480@60 raster timing shared by the VGA timing generator and its renderers.
package vga_pkg;

  typedef logic [9:0] coord_t;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  localparam int H_TOTAL_DEF = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  localparam int V_TOTAL_DEF = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  // Sync pulse spans are half-open: [start, end)
  localparam int HS_START_DEF = H_VISIBLE_DEF + H_FRONT_DEF;
  localparam int HS_END_DEF   = HS_START_DEF + H_SYNC_DEF;
  localparam int VS_START_DEF = V_VISIBLE_DEF + V_FRONT_DEF;
  localparam int VS_END_DEF   = VS_START_DEF + V_SYNC_DEF;

endpackage

// File: rtl/vga_if.sv
// Raster outputs of the timing generator as seen by renderers.
interface vga_if;
  import vga_pkg::*;

  coord_t      DrawX;
  coord_t      DrawY;
  logic        blank;
  logic        hs;
  logic        vs;
  logic        line_start;
  logic        frame_start;
  logic [15:0] frame_count;

  modport master (
    output DrawX, DrawY, blank, hs, vs, line_start, frame_start, frame_count
  );

  modport slave (
    input DrawX, DrawY, blank, hs, vs, line_start, frame_start, frame_count
  );
endinterface

// File: rtl/vga_delay_line.sv
// Resettable shift register that aligns sync/blank with registered renderer colour.
module vga_delay_line #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_pass
    logic unused_s;
    assign unused_s = clk ^ reset;
    assign dout     = din;
  end else begin : g_shift
    logic [WIDTH-1:0] stage_r [DEPTH];

    // Shift one stage per clock; reset flushes every stage to the inactive pattern
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < DEPTH; i++) begin
          stage_r[i] <= RESET_VAL;
        end
      end else begin
        stage_r[0] <= din;
        for (int i = 1; i < DEPTH; i++) begin
          stage_r[i] <= stage_r[i-1];
        end
      end
    end

    assign dout = stage_r[DEPTH-1];
  end

endmodule

// File: rtl/vga_param_chk.sv
// Elaboration-time sanity checks on the raster geometry and sync delay.
module vga_param_chk #(
  parameter int H_TOTAL    = 800,
  parameter int V_TOTAL    = 525,
  parameter int SYNC_DELAY = 1
) ();

  if (H_TOTAL > 1024) begin : g_h_total_err
    $error("vga_param_chk: H_TOTAL exceeds 10-bit counter range");
  end

  if (V_TOTAL > 1024) begin : g_v_total_err
    $error("vga_param_chk: V_TOTAL exceeds 10-bit counter range");
  end

  if ((SYNC_DELAY < 0) || (SYNC_DELAY > 4)) begin : g_delay_err
    $error("vga_param_chk: SYNC_DELAY outside 0..4");
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster counters, sync/blank decode and frame counter for palettized renderers.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_VISIBLE  = H_VISIBLE_DEF,
  parameter int H_FRONT    = H_FRONT_DEF,
  parameter int H_SYNC     = H_SYNC_DEF,
  parameter int H_BACK     = H_BACK_DEF,
  parameter int V_VISIBLE  = V_VISIBLE_DEF,
  parameter int V_FRONT    = V_FRONT_DEF,
  parameter int V_SYNC     = V_SYNC_DEF,
  parameter int V_BACK     = V_BACK_DEF,
  parameter int SYNC_DELAY = 1
) (
  input  logic  vga_clk,
  input  logic  reset,
  vga_if.master vga
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam coord_t H_LAST_C   = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST_C   = coord_t'(V_TOTAL - 1);
  localparam coord_t H_VIS_C    = coord_t'(H_VISIBLE);
  localparam coord_t V_VIS_C    = coord_t'(V_VISIBLE);
  localparam coord_t HS_START_C = coord_t'(H_VISIBLE + H_FRONT);
  localparam coord_t HS_END_C   = coord_t'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam coord_t VS_START_C = coord_t'(V_VISIBLE + V_FRONT);
  localparam coord_t VS_END_C   = coord_t'(V_VISIBLE + V_FRONT + V_SYNC);

  vga_param_chk #(
    .H_TOTAL    (H_TOTAL),
    .V_TOTAL    (V_TOTAL),
    .SYNC_DELAY (SYNC_DELAY)
  ) u_param_chk ();

  coord_t      hc_r;
  coord_t      vc_r;
  logic [15:0] frame_count_r;
  logic        h_wrap_s;
  logic        vis_s;
  logic        hs_raw_s;
  logic        vs_raw_s;
  logic [2:0]  sync_dly_s;

  assign h_wrap_s = (hc_r == H_LAST_C);

  // Pixel/line counters; vc and frame_count advance only on the hc wrap edge
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      hc_r          <= 10'd0;
      vc_r          <= 10'd0;
      frame_count_r <= 16'd0;
    end else if (h_wrap_s) begin
      hc_r <= 10'd0;
      if (vc_r == V_LAST_C) begin
        vc_r          <= 10'd0;
        frame_count_r <= frame_count_r + 16'd1;
      end else begin
        vc_r          <= vc_r + 10'd1;
        frame_count_r <= frame_count_r;
      end
    end else begin
      hc_r          <= hc_r + 10'd1;
      vc_r          <= vc_r;
      frame_count_r <= frame_count_r;
    end
  end

  // Undelayed decode of the registered counters
  always_comb begin
    vis_s    = (hc_r < H_VIS_C) && (vc_r < V_VIS_C);
    hs_raw_s = !((hc_r >= HS_START_C) && (hc_r < HS_END_C));
    vs_raw_s = !((vc_r >= VS_START_C) && (vc_r < VS_END_C));
  end

  vga_delay_line #(
    .WIDTH     (3),
    .DEPTH     (SYNC_DELAY),
    .RESET_VAL (3'b011)
  ) u_sync_dly (
    .clk   (vga_clk),
    .reset (reset),
    .din   ({vis_s, hs_raw_s, vs_raw_s}),
    .dout  (sync_dly_s)
  );

  assign vga.DrawX       = hc_r;
  assign vga.DrawY       = vc_r;
  assign vga.blank       = sync_dly_s[2];
  assign vga.hs          = sync_dly_s[1];
  assign vga.vs          = sync_dly_s[0];
  assign vga.line_start  = (hc_r == 10'd0);
  assign vga.frame_start = (hc_r == 10'd0) && (vc_r == 10'd0);
  assign vga.frame_count = frame_count_r;

endmodule
